// File: rtl/link_power_pkg.sv
// Shared types and helpers for the link power sequencer: state encoding,
// counter sizing and per-channel state field placement.
package link_power_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_DETECT  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RAMP    = 3'd3,
        ST_POWERED = 3'd4,
        ST_FAULT   = 3'd5
    } lps_state_e;

    // Counter width: clog2 of the largest cycle parameter, never below 1.
    function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // LSB of channel ch's field inside the packed ChannelState vector.
    function automatic int unsigned state_lsb(input int unsigned ch);
        return STATE_W * ch;
    endfunction

endpackage

// File: rtl/link_power_channel.sv
// Per-pair-group power FSM: load detect, token-gated soft-start, powered
// monitoring and fault backoff, with a single shared saturating counter.
module link_power_channel
    import link_power_pkg::*;
#(
    parameter int unsigned DETECT_CYCLES = 16,
    parameter int unsigned RAMP_CYCLES   = 64,
    parameter int unsigned RETRY_CYCLES  = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_sense,
    input  logic               i_fault,
    input  logic               i_fault_clear,
    input  logic               i_grant,
    output logic               o_power_on,
    output logic               o_ramp_active,
    output logic [STATE_W-1:0] o_state,
    output logic               o_fault_sticky,
    output logic               o_in_ramp_c,
    output logic               o_in_wait_c,
    output logic               o_powered_next_c
);

    localparam int unsigned CNT_W = cnt_w(DETECT_CYCLES, RAMP_CYCLES, RETRY_CYCLES);
    localparam logic [CNT_W-1:0] DET_LAST   = CNT_W'(DETECT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'(RAMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);

    lps_state_e       r_state;
    lps_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_fault_set;
    logic             r_power_on;
    logic             r_ramp_active;
    logic             r_fault_sticky;

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Fault beats both disable and ramp completion.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fault_set  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && i_sense) begin
                    w_state_next = ST_DETECT;
                    w_cnt_next   = '0;
                end
            end
            ST_DETECT: begin
                if (!i_enable || !i_sense) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == DET_LAST) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_WAIT: begin
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end else if (i_grant) begin
                    w_state_next = ST_RAMP;
                    w_cnt_next   = '0;
                end
            end
            ST_RAMP: begin
                if (i_fault) begin
                    w_state_next = ST_FAULT;
                    w_cnt_next   = '0;
                    w_fault_set  = 1'b1;
                end else if (!i_enable) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == RAMP_LAST) begin
                    w_state_next = ST_POWERED;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            ST_POWERED: begin
                if (i_fault) begin
                    w_state_next = ST_FAULT;
                    w_cnt_next   = '0;
                    w_fault_set  = 1'b1;
                end else if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (r_cnt == RETRY_LAST) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_power_on     <= 1'b0;
            r_ramp_active  <= 1'b0;
            r_fault_sticky <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_power_on     <= (w_state_next == ST_RAMP) || (w_state_next == ST_POWERED);
            r_ramp_active  <= (w_state_next == ST_RAMP);
            r_fault_sticky <= w_fault_set | (r_fault_sticky & ~i_fault_clear);
        end
    end

    assign o_power_on       = r_power_on;
    assign o_ramp_active    = r_ramp_active;
    assign o_state          = r_state;
    assign o_fault_sticky   = r_fault_sticky;
    assign o_in_ramp_c      = (r_state == ST_RAMP);
    assign o_in_wait_c      = (r_state == ST_WAIT);
    assign o_powered_next_c = (w_state_next == ST_POWERED);

endmodule

// File: rtl/link_power_sequencer.sv
// Sequences CHANNELS pair groups; a round-robin ramp token keeps soft-starts
// one at a time to bound inrush on the shared supply.
module link_power_sequencer
    import link_power_pkg::*;
#(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned DETECT_CYCLES = 16,
    parameter int unsigned RAMP_CYCLES   = 64,
    parameter int unsigned RETRY_CYCLES  = 1024
) (
    input  logic                          Clock100Mhz,
    input  logic                          Reset,
    input  logic [CHANNELS-1:0]           Enable,
    input  logic [CHANNELS-1:0]           PairSense,
    input  logic [CHANNELS-1:0]           PairFault,
    input  logic [CHANNELS-1:0]           FaultClear,
    output logic [CHANNELS-1:0]           PowerOn,
    output logic [CHANNELS-1:0]           RampActive,
    output logic [STATE_W*CHANNELS-1:0]   ChannelState,
    output logic [CHANNELS-1:0]           FaultSticky,
    output logic                          AllPowered
);

    localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] w_grant;
    logic [CHANNELS-1:0] w_in_ramp;
    logic [CHANNELS-1:0] w_in_wait;
    logic [CHANNELS-1:0] w_pow_next;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_ptr_next;
    logic                r_all_powered;
    logic                w_all_next;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        link_power_channel #(
            .DETECT_CYCLES (DETECT_CYCLES),
            .RAMP_CYCLES   (RAMP_CYCLES),
            .RETRY_CYCLES  (RETRY_CYCLES)
        ) u_ch (
            .i_clk            (Clock100Mhz),
            .i_reset          (Reset),
            .i_enable         (Enable[g]),
            .i_sense          (PairSense[g]),
            .i_fault          (PairFault[g]),
            .i_fault_clear    (FaultClear[g]),
            .i_grant          (w_grant[g]),
            .o_power_on       (PowerOn[g]),
            .o_ramp_active    (RampActive[g]),
            .o_state          (ChannelState[state_lsb(g) +: STATE_W]),
            .o_fault_sticky   (FaultSticky[g]),
            .o_in_ramp_c      (w_in_ramp[g]),
            .o_in_wait_c      (w_in_wait[g]),
            .o_powered_next_c (w_pow_next[g])
        );
    end

    // Token is free only when nobody is ramping; a grant this cycle means RAMP next.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        w_grant    = '0;
        w_ptr_next = r_ptr;
        found      = 1'b0;
        idx        = '0;
        if (~|w_in_ramp) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                idx = PTR_W'((32'(r_ptr) + k) % CHANNELS);
                if (!found && w_in_wait[idx]) begin
                    found        = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_ptr_next   = PTR_W'((32'(idx) + 32'd1) % CHANNELS);
                end
            end
        end
    end

    assign w_all_next = (|Enable) && (&(~Enable | w_pow_next));

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            r_ptr         <= '0;
            r_all_powered <= 1'b0;
        end else begin
            r_ptr         <= w_ptr_next;
            r_all_powered <= w_all_next;
        end
    end

    assign AllPowered = r_all_powered;

endmodule

// File: doc/link_power_sequencer.md
Name: link_power_sequencer

Overview:
- Parametrised power-up sequencer for CHANNELS TIA-568B pair groups. The default of 2 covers pairs 1236 and 5478.
- Each channel is qualified by a debounced load-sense. Powered channels are monitored for overcurrent. A faulted channel is retried after a backoff.
- A shared round-robin ramp token guarantees that at most one channel soft-starts at a time, which limits inrush on the split supply.
- Sits between the raw power/LNA path and the per-pair op-amp drivers, clocked from the 100 MHz crystal-derived clock.

Parameters:
- CHANNELS, 2, number of pair groups sequenced.
- DETECT_CYCLES, 16, consecutive PairSense-high cycles required to qualify a load.
- RAMP_CYCLES, 64, soft-start duration per channel.
- RETRY_CYCLES, 1024, backoff after a fault before returning to IDLE.

Ports:
- Clock100Mhz  input  1  single system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high.
- Enable  input  CHANNELS  per-channel power request.
- PairSense  input  CHANNELS  valid load signature present; already synchronised upstream.
- PairFault  input  CHANNELS  overcurrent indication; level-sensitive.
- FaultClear  input  CHANNELS  single-cycle pulse that clears FaultSticky.
- PowerOn  output  CHANNELS  drive power to the pair.
- RampActive  output  CHANNELS  channel is in soft-start.
- ChannelState  output  3*CHANNELS  per-channel FSM state, channel i at bits [3i+2:3i].
- FaultSticky  output  CHANNELS  latched fault flag.
- AllPowered  output  1  every enabled channel is POWERED and at least one channel is enabled.

Behaviour:
- Reset:
  - All FSMs go to IDLE, all counters to 0, and the round-robin pointer to 0.
  - PowerOn, RampActive, FaultSticky and AllPowered are all 0.
  - Reset asserted mid-ramp or while powered drops PowerOn on the next edge.
- All outputs are registered.
- State encoding: IDLE=0, DETECT=1, WAIT=2, RAMP=3, POWERED=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE.
- IDLE: if Enable & PairSense, go to DETECT with the counter cleared.
- DETECT:
  - Counter increments each cycle while PairSense=1.
  - Go to WAIT when the counter reaches DETECT_CYCLES-1 with PairSense still 1. A channel therefore spends exactly DETECT_CYCLES cycles in DETECT.
  - PairSense=0 returns the channel to IDLE.
- WAIT: holds until granted the ramp token, then goes to RAMP on the next edge.
- RAMP:
  - PowerOn=1 and RampActive=1.
  - Counter runs for RAMP_CYCLES cycles, then the channel goes to POWERED.
- POWERED: PowerOn=1 and RampActive=0.
- Fault handling:
  - PairFault=1 while in RAMP or POWERED sends the channel to FAULT and sets FaultSticky.
  - On the transition edge PowerOn drops and RampActive clears.
  - A fault has priority over ramp completion in the same cycle.
- FAULT:
  - PowerOn=0.
  - Counter runs for RETRY_CYCLES cycles, then the channel goes to IDLE, whether or not Enable is high.
- Enable=0 in DETECT, WAIT, RAMP or POWERED sends the channel to IDLE on the next edge and drops PowerOn.
- Enable=0 does not abort FAULT.
- FaultSticky:
  - Cleared by FaultClear.
  - If a fault set and a FaultClear arrive in the same cycle, the set wins.
- Ramp token arbiter:
  - A grant is issued only in a cycle where no channel is in RAMP and no channel is entering RAMP.
  - Candidates are channels in WAIT. The search starts at the pointer and wraps modulo CHANNELS.
  - After a grant the pointer becomes grantee+1, mod CHANNELS.
  - At most one grant per cycle.
  - A channel leaving RAMP, whether by completion, fault or disable, frees the token for grant in the following cycle.
- Counter width is clog2 of the largest cycle parameter. Counters saturate and never wrap.

Decomposition:
- Shared package link_power_pkg holds:
  - the state enum and encodings;
  - the CNT_W function;
  - the ChannelState slice helper.
- Sub-module link_power_channel holds the per-channel FSM and counter. It has a grant input and an in-ramp output.
- The top level holds the generate loop, the round-robin arbiter and the AllPowered reduction.

Test Plan:
- Single channel, defaults:
  - Stimulus: Enable[0]=PairSense[0]=1 from cycle 0.
  - Required response: DETECT at 1, WAIT at 17, RAMP with PowerOn[0]=1 at 18, POWERED at 82; AllPowered=1 at 82 with Enable[1]=0.
- Both channels, simultaneous:
  - Stimulus: both enabled at cycle 0.
  - Required response: ch0 RAMP 18–81; ch1 waits and enters RAMP at 83 (token freed at 82, granted at 82); never both RampActive.
- Sense glitch:
  - Stimulus: PairSense[0] low for one cycle at cycle 10 of DETECT.
  - Required response: returns to IDLE; re-detect takes the full 16 cycles after sense returns.
- Fault in POWERED:
  - Stimulus: PairFault[0]=1 at cycle 100.
  - Required response: FAULT and PowerOn[0]=0 at 101; FaultSticky[0]=1; IDLE at 1125; redetects if still enabled.
- Fault at last ramp cycle:
  - Stimulus: PairFault coincides with the final ramp cycle.
  - Required response: FAULT, not POWERED.
- FaultClear coincident with new fault:
  - Stimulus: FaultClear and a new fault in the same cycle.
  - Required response: FaultSticky stays 1.
- Reset mid-ramp:
  - Stimulus: Reset=1 at cycle 40.
  - Required response: all outputs 0 at 41; pointer 0; next grant goes to ch0 when both are waiting.
